// File: rtl/wb_buttons_leds_master.sv
// Wishbone initiator: polls buttons, debounces, toggles LEDs on press.
// Counts transactions that end without an ack.
module wb_buttons_leds_master #(
  parameter logic [31:0] LED_ADDR    = 32'h3000_0000,
  parameter logic [31:0] BUTTON_ADDR = 32'h3000_0004,
  parameter int          POLL_DIV    = 1000,
  parameter int          DEBOUNCE_N  = 4,
  parameter int          TIMEOUT     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  input  logic        i_wb_ack,
  input  logic        i_wb_stall,
  input  logic [31:0] i_wb_data,
  output logic [1:0]  buttons_db,
  output logic [1:0]  led_state,
  output logic [7:0]  timeout_cnt
);

  localparam int PW = $clog2(POLL_DIV);
  localparam int DW = $clog2(DEBOUNCE_N + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_DIV - 1);
  localparam logic [DW-1:0] DB_N      = DW'(DEBOUNCE_N);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT
  } state_t;

  state_t state;
  state_t state_nx;

  logic [PW-1:0]        poll_cnt;
  logic                 poll_tick;
  logic [TW-1:0]        wait_cnt;
  logic                 in_wait;
  logic                 rd_ack;
  logic                 tmo_event;
  logic [1:0]           prev_smp;
  logic [1:0][DW-1:0]   db_cnt;
  logic [1:0][DW-1:0]   db_cnt_nx;
  logic [1:0]           db_nx;
  logic [1:0]           press;
  logic                 unused_data;

  assign unused_data = ^i_wb_data[31:2];

  assign poll_tick = enable && (poll_cnt == POLL_LAST);
  assign in_wait   = (state == RD_WAIT) || (state == WR_WAIT);
  assign rd_ack    = (state == RD_WAIT) && i_wb_ack;
  assign tmo_event = in_wait && !i_wb_ack && (wait_cnt == TMO_LAST);

  // Poll divider; held at zero while disabled so re-enable restarts it.
  always_ff @(posedge clk) begin
    if (reset || !enable)
      poll_cnt <= '0;
    else if (poll_cnt == POLL_LAST)
      poll_cnt <= '0;
    else
      poll_cnt <= poll_cnt + 1'b1;
  end

  // Per-bit debounce of the sample on the ack cycle.
  // The first differing sample counts as one of the DEBOUNCE_N.
  always_comb begin
    db_nx     = buttons_db;
    db_cnt_nx = db_cnt;
    for (int i = 0; i < 2; i++) begin
      if (i_wb_data[i] == buttons_db[i])
        db_cnt_nx[i] = '0;
      else if (i_wb_data[i] == prev_smp[i])
        db_cnt_nx[i] = db_cnt[i] + 1'b1;
      else
        db_cnt_nx[i] = DW'(1);
      if (db_cnt_nx[i] >= DB_N) begin
        db_cnt_nx[i] = '0;
        db_nx[i]     = i_wb_data[i];
      end
    end
    press = db_nx & ~buttons_db;
  end

  // Transaction sequencing: read buttons, optionally write LEDs.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (poll_tick) state_nx = RD_REQ;
      RD_REQ:  if (!i_wb_stall) state_nx = RD_WAIT;
      RD_WAIT: begin
        if (i_wb_ack)
          state_nx = (|press) ? WR_REQ : IDLE;
        else if (tmo_event)
          state_nx = IDLE;
      end
      WR_REQ:  if (!i_wb_stall) state_nx = WR_WAIT;
      WR_WAIT: if (i_wb_ack || tmo_event) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Bus outputs are a pure function of state and the LED register.
  always_comb begin
    o_wb_cyc  = (state != IDLE);
    o_wb_stb  = (state == RD_REQ) || (state == WR_REQ);
    o_wb_we   = (state == WR_REQ) || (state == WR_WAIT);
    o_wb_addr = '0;
    if (o_wb_we)
      o_wb_addr = LED_ADDR;
    else if (o_wb_cyc)
      o_wb_addr = BUTTON_ADDR;
    o_wb_data = {30'b0, led_state};
  end

  // State register and ack-wait counter, cleared on each state change.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state <= state_nx;
      if (in_wait && state_nx == state)
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
    end
  end

  // Debounce state and LED toggle, committed only on a read ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_smp   <= '0;
      db_cnt     <= '0;
      buttons_db <= '0;
      led_state  <= '0;
    end else if (rd_ack) begin
      prev_smp   <= i_wb_data[1:0];
      db_cnt     <= db_cnt_nx;
      buttons_db <= db_nx;
      led_state  <= led_state ^ press;
    end
  end

  // Saturating count of transactions abandoned for lack of ack.
  always_ff @(posedge clk) begin
    if (reset)
      timeout_cnt <= '0;
    else if (tmo_event && timeout_cnt != 8'hFF)
      timeout_cnt <= timeout_cnt + 1'b1;
  end

endmodule

// File: tb/tb_wb_buttons_leds_master.sv
// Directed bench for wb_buttons_leds_master.
// Bench acts as the bus responder and checks each poll.
module tb_wb_buttons_leds_master;

  localparam logic [31:0] LED_A = 32'h3000_0000;
  localparam logic [31:0] BTN_A = 32'h3000_0004;
  localparam int          PDIV  = 8;
  localparam int          DBN   = 2;
  localparam int          TMO   = 4;
  localparam int          NV    = 23;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic        o_wb_we;
  logic [31:0] o_wb_addr;
  logic [31:0] o_wb_data;
  logic        i_wb_ack;
  logic        i_wb_stall;
  logic [31:0] i_wb_data;
  logic [1:0]  buttons_db;
  logic [1:0]  led_state;
  logic [7:0]  timeout_cnt;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  int acc_n  = 0;
  int we_n   = 0;
  int mark   = 0;

  typedef struct {
    logic [1:0] rd;
    int         stall;
    bit         rd_ack;
    bit         wr_ack;
    logic [1:0] db;
    logic [1:0] led;
    bit         wr;
    logic [7:0] tmo;
  } vec_t;

  vec_t vt [NV];

  wb_buttons_leds_master #(
    .LED_ADDR    (LED_A),
    .BUTTON_ADDR (BTN_A),
    .POLL_DIV    (PDIV),
    .DEBOUNCE_N  (DBN),
    .TIMEOUT     (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .o_wb_cyc    (o_wb_cyc),
    .o_wb_stb    (o_wb_stb),
    .o_wb_we     (o_wb_we),
    .o_wb_addr   (o_wb_addr),
    .o_wb_data   (o_wb_data),
    .i_wb_ack    (i_wb_ack),
    .i_wb_stall  (i_wb_stall),
    .i_wb_data   (i_wb_data),
    .buttons_db  (buttons_db),
    .led_state   (led_state),
    .timeout_cnt (timeout_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (!reset && o_wb_stb && !i_wb_stall)
      acc_n <= acc_n + 1;
    if (o_wb_we)
      we_n <= we_n + 1;
  end

  function automatic void chk(input string nm,
                              input logic [63:0] act,
                              input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  task automatic wait_rise(input string nm, input int gap);
    int n;
    n = 0;
    while (!o_wb_cyc && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_seen"}, 64'(o_wb_cyc), 64'd1);
    if (gap >= 0)
      chk({nm, "_gap"}, 64'(cycle - mark), 64'(gap));
    mark = cycle;
  endtask

  task automatic wait_tmo(input string nm);
    for (int k = 1; k < TMO; k++) begin
      @(negedge clk);
      chk(nm, {62'd0, o_wb_cyc, o_wb_stb}, 64'd2);
    end
    @(negedge clk);
  endtask

  task automatic do_poll(input int idx, input vec_t v);
    int a0;
    string s;
    s = $sformatf("v%0d", idx);
    wait_rise({s, "_poll"}, PDIV);
    a0 = acc_n;
    chk({s, "_rd_req"}, {o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr},
        {3'b110, BTN_A});
    i_wb_data = {30'd0, v.rd};
    for (int k = 0; k < v.stall; k++) begin
      i_wb_stall = 1'b1;
      @(negedge clk);
      chk({s, "_stall_hold"}, {o_wb_stb, o_wb_addr}, {1'b1, BTN_A});
    end
    i_wb_stall = 1'b0;
    @(negedge clk);
    chk({s, "_rd_wait"}, {o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr},
        {3'b100, BTN_A});
    if (v.rd_ack) begin
      i_wb_ack = 1'b1;
      @(negedge clk);
      i_wb_ack = 1'b0;
    end else begin
      wait_tmo({s, "_rd_tmo"});
    end
    if (v.wr) begin
      chk({s, "_wr_req"}, {o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr},
          {3'b111, LED_A});
      chk({s, "_wr_data"}, 64'(o_wb_data), {62'd0, v.led});
      @(negedge clk);
      chk({s, "_wr_wait"}, {o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr},
          {3'b101, LED_A});
      if (v.wr_ack) begin
        i_wb_ack = 1'b1;
        @(negedge clk);
        i_wb_ack = 1'b0;
      end else begin
        wait_tmo({s, "_wr_tmo"});
      end
    end
    chk({s, "_end_idle"}, 64'(o_wb_cyc), 64'd0);
    chk({s, "_db"}, 64'(buttons_db), 64'(v.db));
    chk({s, "_led"}, 64'(led_state), 64'(v.led));
    chk({s, "_tmo"}, 64'(timeout_cnt), 64'(v.tmo));
    chk({s, "_accepts"}, 64'(acc_n - a0), 64'(1 + int'(v.wr)));
  endtask

  initial begin
    int we0;
    int busy;
    //         rd     stl ra wa db     led    wr tmo
    vt[0]  = '{2'b00, 0, 1, 1, 2'b00, 2'b00, 0, 8'd0};
    vt[1]  = '{2'b00, 0, 1, 1, 2'b00, 2'b00, 0, 8'd0};
    vt[2]  = '{2'b01, 0, 1, 1, 2'b00, 2'b00, 0, 8'd0};
    vt[3]  = '{2'b01, 0, 1, 1, 2'b01, 2'b01, 1, 8'd0};
    vt[4]  = '{2'b01, 0, 1, 1, 2'b01, 2'b01, 0, 8'd0};
    vt[5]  = '{2'b11, 0, 1, 1, 2'b01, 2'b01, 0, 8'd0};
    vt[6]  = '{2'b01, 0, 1, 1, 2'b01, 2'b01, 0, 8'd0};
    vt[7]  = '{2'b11, 0, 1, 1, 2'b01, 2'b01, 0, 8'd0};
    vt[8]  = '{2'b01, 0, 1, 1, 2'b01, 2'b01, 0, 8'd0};
    vt[9]  = '{2'b01, 3, 1, 1, 2'b01, 2'b01, 0, 8'd0};
    vt[10] = '{2'b00, 0, 1, 1, 2'b01, 2'b01, 0, 8'd0};
    vt[11] = '{2'b00, 0, 1, 1, 2'b00, 2'b01, 0, 8'd0};
    vt[12] = '{2'b11, 0, 1, 1, 2'b00, 2'b01, 0, 8'd0};
    vt[13] = '{2'b11, 0, 1, 1, 2'b11, 2'b10, 1, 8'd0};
    vt[14] = '{2'b01, 0, 1, 1, 2'b11, 2'b10, 0, 8'd0};
    vt[15] = '{2'b01, 0, 1, 1, 2'b01, 2'b10, 0, 8'd0};
    vt[16] = '{2'b11, 0, 1, 1, 2'b01, 2'b10, 0, 8'd0};
    vt[17] = '{2'b11, 0, 1, 0, 2'b11, 2'b00, 1, 8'd1};
    vt[18] = '{2'b11, 0, 1, 1, 2'b11, 2'b00, 0, 8'd1};
    vt[19] = '{2'b00, 0, 0, 1, 2'b11, 2'b00, 0, 8'd2};
    vt[20] = '{2'b00, 0, 1, 1, 2'b11, 2'b00, 0, 8'd2};
    vt[21] = '{2'b00, 0, 1, 1, 2'b00, 2'b00, 0, 8'd2};
    vt[22] = '{2'b01, 0, 1, 1, 2'b00, 2'b00, 0, 8'd2};

    reset      = 1'b1;
    enable     = 1'b1;
    i_wb_ack   = 1'b0;
    i_wb_stall = 1'b0;
    i_wb_data  = '0;
    repeat (3) @(negedge clk);
    chk("rst_bus", {o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data},
        64'd0);
    chk("rst_regs", {buttons_db, led_state, timeout_cnt}, 64'd0);
    reset = 1'b0;
    mark  = cycle;

    for (int i = 0; i < NV; i++)
      do_poll(i, vt[i]);

    // Reset while the LED write waits for its ack.
    wait_rise("rst_poll", PDIV);
    i_wb_data = 32'd1;
    @(negedge clk);
    i_wb_ack = 1'b1;
    @(negedge clk);
    i_wb_ack = 1'b0;
    chk("rst_wr_req", {o_wb_stb, o_wb_we, o_wb_data}, {2'b11, 32'd1});
    chk("rst_led_new", 64'(led_state), 64'd1);
    @(negedge clk);
    chk("rst_in_wr_wait", {o_wb_cyc, o_wb_stb, o_wb_we}, 64'b101);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_bus", {o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr}, 64'd0);
    chk("mid_rst_regs", {buttons_db, led_state, timeout_cnt}, 64'd0);
    we0       = we_n;
    i_wb_data = '0;
    reset     = 1'b0;
    mark      = cycle;

    // Drop enable during a read; it must still complete.
    wait_rise("en_poll", PDIV);
    enable = 1'b0;
    @(negedge clk);
    chk("en_rd_wait", {o_wb_cyc, o_wb_stb}, 64'b10);
    i_wb_ack = 1'b1;
    @(negedge clk);
    i_wb_ack = 1'b0;
    chk("en_done", 64'(o_wb_cyc), 64'd0);
    busy = 0;
    for (int k = 0; k < 3 * PDIV; k++) begin
      @(negedge clk);
      if (o_wb_cyc) busy++;
    end
    chk("disabled_quiet", 64'(busy), 64'd0);

    // Re-enable restarts the divider from zero.
    enable = 1'b1;
    mark   = cycle;
    wait_rise("reen_poll", PDIV);
    @(negedge clk);
    i_wb_ack = 1'b1;
    @(negedge clk);
    i_wb_ack = 1'b0;
    chk("reen_done", 64'(o_wb_cyc), 64'd0);
    chk("no_wr_after_rst", 64'(we_n - we0), 64'd0);
    chk("reen_regs", {buttons_db, led_state, timeout_cnt}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
